fetch_unit: RTL

Instruction fetch front end: owns the program counter, issues in-order word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions in a 2-entry queue toward decode. It is the consumer of the branch/jump redirect (`pc_src`/`pc_target`) produced at execute. On a redirect it flushes the queue and discards in-flight wrong-path responses.

---
 rtl/fetch_unit.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and in-order instruction fetch front end with a 2-entry decode queue.
// Redirects flush the queue and discard wrong-path responses still in flight.
module fetch_unit #(
    parameter int DataWidth = 32,
    parameter int AddressWidth = 10,
    parameter logic [AddressWidth-1:0] ResetPc = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    redirect_i,
    input  logic [AddressWidth-1:0] redirect_target_i,
    output logic                    imem_req_valid_o,
    input  logic                    imem_req_ready_i,
    output logic [AddressWidth-1:0] imem_req_addr_o,
    input  logic                    imem_rsp_valid_i,
    input  logic [DataWidth-1:0]    imem_rsp_data_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [DataWidth-1:0]    instr_o,
    output logic [AddressWidth-1:0] instr_pc_o,
    output logic [AddressWidth-1:0] instr_pc_plus4_o
);
    logic [AddressWidth-1:0] r_fetch_pc;
    logic [DataWidth-1:0]    r_q_instr [2];
    logic [AddressWidth-1:0] r_q_pc [2];
    logic [AddressWidth-1:0] r_tag [2];
    logic                    r_head;
    logic                    r_tag_head;
    logic [1:0]              r_count;
    logic [1:0]              r_inflight;
    logic [1:0]              r_drop;
    logic                    w_pop;
    logic                    w_acc;
    logic                    w_rsp;
    logic                    w_push;
    logic [2:0]              w_credit;

    assign instr_valid_o    = !rst_i && !redirect_i && r_count != 2'd0;
    assign w_pop            = instr_valid_o && instr_ready_i;
    // queued plus in-flight never exceeds the two queue slots, so a response always has room
    assign w_credit         = {1'b0, r_count} + {1'b0, r_inflight} - {2'b00, w_pop};
    assign imem_req_valid_o = !rst_i && !redirect_i && w_credit < 3'd2;
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_acc            = imem_req_valid_o && imem_req_ready_i;
    assign w_rsp            = imem_rsp_valid_i && r_inflight != 2'd0;
    assign w_push           = w_rsp && r_drop == 2'd0;
    assign instr_o          = r_q_instr[r_head];
    assign instr_pc_o       = r_q_pc[r_head];
    assign instr_pc_plus4_o = r_q_pc[r_head] + AddressWidth'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= ResetPc;
            r_head     <= 1'b0;
            r_tag_head <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 2'd0;
            r_drop     <= 2'd0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_target_i[AddressWidth-1:2], 2'b00};
            r_count    <= 2'd0;
            r_inflight <= r_inflight - {1'b0, w_rsp};
            r_drop     <= r_inflight - {1'b0, w_rsp};
            r_tag_head <= r_tag_head ^ w_rsp;
        end else begin
            if (w_acc) begin
                r_fetch_pc                          <= r_fetch_pc + AddressWidth'(4);
                r_tag[r_tag_head ^ r_inflight[0]]   <= r_fetch_pc;
            end
            if (w_push) begin
                r_q_instr[r_head ^ r_count[0]] <= imem_rsp_data_i;
                r_q_pc[r_head ^ r_count[0]]    <= r_tag[r_tag_head];
            end
            r_inflight <= r_inflight + {1'b0, w_acc} - {1'b0, w_rsp};
            r_drop     <= r_drop - {1'b0, w_rsp && r_drop != 2'd0};
            r_tag_head <= r_tag_head ^ w_rsp;
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_head     <= r_head ^ w_pop;
        end
    end
endmodule
